// File: rtl/alu_exec_stage.sv
// alu_exec_stage: CPU register file plus execute/write-back sequencer around alu8,
// including the two-pass ADD HL,rr (ADD low byte, ADC high byte).
module alu_exec_stage #(
  parameter logic [15:0] RST_AF = 16'h01B0,
  parameter logic [15:0] RST_BC = 16'h0013,
  parameter logic [15:0] RST_DE = 16'h00D8,
  parameter logic [15:0] RST_HL = 16'h014D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is16,
  input  logic [3:0]  op,
  input  logic [2:0]  src_sel,
  input  logic [1:0]  rr_sel,
  input  logic [7:0]  imm8,
  input  logic [15:0] sp_in,
  input  logic [3:0]  flag_mask,
  input  logic        ld_en,
  input  logic [2:0]  ld_sel,
  input  logic [7:0]  ld_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flags,
  output logic        busy,
  output logic        done,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_f,
  output logic [15:0] hl
);
  typedef enum logic [1:0] {IDLE, EXEC8, ADD16_LO, ADD16_HI} state_t;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_CP  = 4'd4;
  localparam logic [2:0] SEL_F  = 3'd6;
  localparam logic [2:0] SEL_IMM = 3'd6;
  // register file indexed by the ld_sel encoding: B,C,D,E,H,L,F,A
  state_t      state_q, state_d;
  logic [7:0]  r_q [8];
  logic [7:0]  r_d [8];
  logic [3:0]  op_q, op_d, mask_q, mask_d;
  logic [2:0]  src_q, src_d;
  logic [7:0]  imm_q, imm_d;
  logic [15:0] rr_q, rr_d;
  logic        cy_q, cy_d, done_q, done_d;
  logic [7:0]  opnd;
  logic [15:0] rr_val;
  logic        unused_flags;
  assign unused_flags = ^alu_flags[3:0];
  assign opnd = src_q == SEL_IMM ? imm_q : r_q[src_q];
  // the 16-bit operand is snapshotted at start so ADD HL,HL sees the pre-write L
  assign rr_val = rr_sel == 2'd0 ? {r_q[0], r_q[1]} :
                  rr_sel == 2'd1 ? {r_q[2], r_q[3]} :
                  rr_sel == 2'd2 ? {r_q[4], r_q[5]} : sp_in;
  assign busy  = state_q != IDLE;
  assign done  = done_q;
  assign reg_a = r_q[7];
  assign reg_f = r_q[6];
  assign hl    = {r_q[4], r_q[5]};
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    op_d       = op_q;
    mask_d     = mask_q;
    src_d      = src_q;
    imm_d      = imm_q;
    rr_d       = rr_q;
    cy_d       = cy_q;
    done_d     = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    alu_cin    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          src_d   = src_sel;
          imm_d   = imm8;
          mask_d  = flag_mask;
          rr_d    = rr_val;
          state_d = is16 ? ADD16_LO : EXEC8;
        end else if (ld_en) begin
          r_d[ld_sel] = ld_sel == SEL_F ? {ld_data[7:4], 4'h0} : ld_data;
        end
      end
      EXEC8: begin
        alu_a      = r_q[7];
        alu_b      = opnd;
        alu_opcode = op_q;
        alu_cin    = r_q[6][4];
        r_d[7]     = op_q == OP_CP ? r_q[7] : alu_res;
        r_d[6]     = {(mask_q & alu_flags[7:4]) | (~mask_q & r_q[6][7:4]), 4'h0};
        state_d    = IDLE;
        done_d     = 1'b1;
      end
      ADD16_LO: begin
        alu_a      = r_q[5];
        alu_b      = rr_q[7:0];
        alu_opcode = OP_ADD;
        r_d[5]     = alu_res;
        cy_d       = alu_flags[4];
        state_d    = ADD16_HI;
      end
      default: begin
        alu_a      = r_q[4];
        alu_b      = rr_q[15:8];
        alu_opcode = OP_ADC;
        alu_cin    = cy_q;
        r_d[4]     = alu_res;
        r_d[6]     = {r_q[6][7], 1'b0, alu_flags[5], alu_flags[4], 4'h0};
        state_d    = IDLE;
        done_d     = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q[0]  <= RST_BC[15:8];
      r_q[1]  <= RST_BC[7:0];
      r_q[2]  <= RST_DE[15:8];
      r_q[3]  <= RST_DE[7:0];
      r_q[4]  <= RST_HL[15:8];
      r_q[5]  <= RST_HL[7:0];
      r_q[6]  <= RST_AF[7:0];
      r_q[7]  <= RST_AF[15:8];
      op_q    <= '0;
      mask_q  <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      rr_q    <= '0;
      cy_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      rr_q    <= rr_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized scoreboard bench for alu_exec_stage with an alu8 model
// and a register-file reference model working on whole bytes and 16-bit sums.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is16 = 1'b0, ld_en = 1'b0;
  logic [3:0]  op = '0, flag_mask = '0;
  logic [2:0]  src_sel = '0, ld_sel = '0;
  logic [1:0]  rr_sel = '0;
  logic [7:0]  imm8 = '0, ld_data = '0;
  logic [15:0] sp_in = '0;
  logic [7:0]  alu_a, alu_b, alu_res, alu_flags, reg_a, reg_f;
  logic [3:0]  alu_opcode;
  logic        alu_cin, busy, done;
  logic [15:0] hl;
  logic [7:0]  m [8];
  logic [31:0] q [$];
  int          n_cmp = 0, n_bad = 0;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .start(start), .is16(is16), .op(op), .src_sel(src_sel),
    .rr_sel(rr_sel), .imm8(imm8), .sp_in(sp_in), .flag_mask(flag_mask), .ld_en(ld_en),
    .ld_sel(ld_sel), .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy), .done(done), .reg_a(reg_a), .reg_f(reg_f), .hl(hl)
  );

  always #5 clk = ~clk;

  // alu8 stand-in; flag low nibble is deliberately non-zero
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] o, input logic ci);
    int s, cc;
    logic [7:0] r;
    logic n, h, c;
    n = 1'b0; h = 1'b0; c = 1'b0; r = '0;
    cc = ci ? 1 : 0;
    case (o)
      4'd0, 4'd1: begin
        if (o == 4'd0) cc = 0;
        s = int'(a) + int'(b) + cc;
        r = s[7:0];
        h = (int'(a & 8'h0F) + int'(b & 8'h0F) + cc) > 15;
        c = s > 255;
      end
      4'd2, 4'd3, 4'd4: begin
        if (o != 4'd3) cc = 0;
        s = int'(a) - int'(b) - cc;
        r = s[7:0];
        n = 1'b1;
        h = int'(a & 8'h0F) < int'(b & 8'h0F) + cc;
        c = int'(a) < int'(b) + cc;
      end
      4'd5: begin r = a & b; h = 1'b1; end
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: begin r = {a[6:0], ci}; c = a[7]; end
      4'd9: begin r = {ci, a[7:1]}; c = a[0]; end
      default: r = '0;
    endcase
    return {r == 8'h00, n, h, c, 4'hA, r};
  endfunction

  always_comb {alu_flags, alu_res} = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else check("writeback", {reg_a, reg_f, hl}, q.pop_front());
    end
  end

  task automatic model_reset();
    m[0] = 8'h00; m[1] = 8'h13; m[2] = 8'h00; m[3] = 8'hD8;
    m[4] = 8'h01; m[5] = 8'h4D; m[6] = 8'hB0; m[7] = 8'h01;
  endtask

  task automatic ld(input logic [2:0] sel, input logic [7:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    m[sel] = sel == 3'd6 ? {d[7:4], 4'h0} : d;
  endtask

  task automatic cmd8(input logic [3:0] o, input logic [2:0] src, input logic [7:0] imm,
                      input logic [3:0] mask);
    logic [15:0] fr;
    logic [7:0] opnd;
    opnd = src == 3'd6 ? imm : m[src];
    fr = alu_fn(m[7], opnd, o, m[6][4]);
    if (o != 4'd4) m[7] = fr[7:0];
    m[6] = {(fr[15:12] & mask) | (m[6][7:4] & ~mask), 4'h0};
    q.push_back({m[7], m[6], m[4], m[5]});
    start = 1'b1; is16 = 1'b0; op = o; src_sel = src; imm8 = imm; flag_mask = mask;
    ld_en = 1'b1; ld_sel = 3'($urandom); ld_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); src_sel = 3'($urandom); imm8 = 8'($urandom); flag_mask = 4'($urandom);
    ld_sel = 3'($urandom); ld_data = 8'($urandom);
    check("busy8", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ld_en = 1'b0;
    check("done8_latency", {30'd0, done, busy}, 32'd2);
  endtask

  // mode 0: plain, 1: start pulsed during the high pass, 2: reset during the high pass
  task automatic cmd16(input logic [1:0] rr, input logic [15:0] sp, input int mode);
    logic [15:0] rv, hv;
    int s;
    logic h, c;
    rv = rr == 2'd0 ? {m[0], m[1]} : rr == 2'd1 ? {m[2], m[3]} :
         rr == 2'd2 ? {m[4], m[5]} : sp;
    hv = {m[4], m[5]};
    s = int'(hv) + int'(rv);
    h = (int'(hv & 16'h0FFF) + int'(rv & 16'h0FFF)) > 16'h0FFF;
    c = s > 16'hFFFF;
    if (mode != 2) begin
      {m[4], m[5]} = s[15:0];
      m[6] = {m[6][7], 1'b0, h, c, 4'h0};
      q.push_back({m[7], m[6], m[4], m[5]});
    end
    start = 1'b1; is16 = 1'b1; rr_sel = rr; sp_in = sp;
    @(negedge clk);
    start = 1'b0; rr_sel = 2'($urandom); sp_in = 16'($urandom);
    check("lo_drive", {26'd0, busy, alu_opcode, alu_cin}, {26'd0, 1'b1, 4'd0, 1'b0});
    @(negedge clk);
    check("hi_drive", {27'd0, busy, alu_opcode}, {27'd0, 1'b1, 4'd1});
    if (mode == 1) begin
      start = 1'b1; is16 = 1'b0; op = 4'd7; src_sel = 3'd6; imm8 = 8'hFF; flag_mask = 4'hF;
    end
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("abort_regs", {reg_a, reg_f, hl}, 32'h01B0014D);
      check("abort_status", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      check("abort_no_done", {30'd0, busy, done}, 32'd0);
    end else begin
      @(negedge clk);
      start = 1'b0;
      check("done16_latency", {30'd0, done, busy}, 32'd2);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_regs", {reg_a, reg_f, hl}, 32'h01B0014D);
    check("reset_status", {30'd0, busy, done}, 32'd0);
    check("idle_alu", {alu_a, alu_b, 11'd0, alu_opcode, alu_cin}, 32'd0);
    ld(3'd7, 8'h3A); ld(3'd0, 8'hC6);
    cmd8(4'd0, 3'd0, 8'h00, 4'hF);
    check("add_result", {16'd0, reg_a, reg_f}, 32'h000000B0);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    ld(3'd7, 8'h3C);
    cmd8(4'd4, 3'd6, 8'h40, 4'hF);
    check("cp_result", {16'd0, reg_a, reg_f}, 32'h00003C50);
    ld(3'd7, 8'hFF); ld(3'd6, 8'h00);
    cmd8(4'd0, 3'd6, 8'h01, 4'b1110);
    check("masked_flags", {16'd0, reg_a, reg_f}, 32'h000000A0);
    ld(3'd4, 8'h8A); ld(3'd5, 8'h23); ld(3'd0, 8'h06); ld(3'd1, 8'h05); ld(3'd6, 8'h80);
    cmd16(2'd0, 16'h0000, 1);
    check("add16_result", {8'd0, reg_f, hl}, 32'h00A09028);
    @(negedge clk);
    check("hi_start_ignored", {30'd0, busy, done}, 32'd0);
    cmd16(2'd0, 16'h0000, 2);
    ld(3'd6, 8'hFF);
    check("f_low_nibble", {24'd0, reg_f}, 32'h000000F0);
    ld(3'd4, 8'h88); ld(3'd5, 8'h99);
    cmd16(2'd2, 16'h0000, 0);
    check("add_hl_hl", {16'd0, hl}, 32'h00001132);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3))
        0: ld(3'($urandom), 8'($urandom));
        1, 2: cmd8(4'($urandom_range(9)), 3'($urandom), 8'($urandom), 4'($urandom));
        default: cmd16(2'($urandom), 16'($urandom), 0);
      endcase
    end
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/write-back stage wrapped around the 8-bit ALU (alu8); owns the CPU register file A,F,B,C,D,E,H,L.
- Selects and drives ALU operands, captures the ALU result and flags, and writes them back under a per-command flag mask.
- Sequences 16-bit ADD HL,rr as two ALU passes: ADD on the low byte, then ADC on the high byte.
- Sits between instruction decode (upstream) and alu8 (combinational, instantiated externally).

Parameters:
- RST_AF, 16'h01B0, reset value of A:F (DMG post-boot).
- RST_BC, 16'h0013, reset value of B:C.
- RST_DE, 16'h00D8, reset value of D:E.
- RST_HL, 16'h014D, reset value of H:L.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- is16  in  1  0 = 8-bit op into A; 1 = ADD HL,rr.
- op  in  4  alu8 opcode for 8-bit commands (ADD=0 … RR=9); ignored when is16=1.
- src_sel  in  3  8-bit operand B: 0=B,1=C,2=D,3=E,4=H,5=L,6=imm8,7=A.
- rr_sel  in  2  16-bit operand: 0=BC,1=DE,2=HL,3=sp_in.
- imm8  in  8  immediate operand.
- sp_in  in  16  stack pointer value (SP is not held here).
- flag_mask  in  4  per-flag update enable {Z,N,H,C}; a 0 bit keeps the old flag.
- ld_en  in  1  direct register load from the rest of the CPU.
- ld_sel  in  3  load target: 0=B,1=C,2=D,3=E,4=H,5=L,6=F,7=A.
- ld_data  in  8  load data.
- alu_a  out  8  to alu8 regA.
- alu_b  out  8  to alu8 regB.
- alu_opcode  out  4  to alu8 opcode.
- alu_cin  out  1  to alu8 carryIn.
- alu_res  in  8  from alu8 res.
- alu_flags  in  8  from alu8 flagsOut.
- busy  out  1  high while a command is in flight.
- done  out  1  one-cycle pulse after final write-back.
- reg_a  out  8  current A.
- reg_f  out  8  current F.
- hl  out  16  current H:L.

Behaviour:
- F layout: Z=bit7, N=6, H=5, C=4; F[3:0] is always 0, including on loads of F.
- Reset (async): registers take their RST_* values; state=IDLE; busy=0; done=0. alu_* outputs follow the state (IDLE drives 0).
- States: IDLE, EXEC8, ADD16_LO, ADD16_HI.
- IDLE:
  - start=1 latches op, src_sel, rr_sel, imm8, sp_in and flag_mask.
  - Next state is EXEC8 (is16=0) or ADD16_LO (is16=1); busy goes high at that edge.
  - ld_en is honoured only in IDLE with start=0; start wins if both are high.
- EXEC8 (1 cycle):
  - Drive alu_a=A, alu_b=selected operand, alu_opcode=latched op, alu_cin=F[4].
  - At the edge: A<=alu_res, except when op=CP(4), which leaves A unchanged.
  - Each flag bit: F[i]<=mask ? alu_flags[i] : F[i].
  - Go to IDLE; done=1 for the following cycle; busy=0.
- ADD16_LO:
  - Drive alu_a=L, alu_b=rr[7:0], opcode=ADD, cin=0.
  - At the edge: L<=alu_res; the internal carry register captures alu_flags[4]; F is untouched.
- ADD16_HI:
  - Drive alu_a=H, alu_b=rr[15:8], opcode=ADC, cin=internal carry.
  - At the edge: H<=alu_res.
  - Flags: Z unchanged, N<=0, H<=alu_flags[5], C<=alu_flags[4]. flag_mask is ignored.
  - Then IDLE with a done pulse.
- rr_sel=2 (ADD HL,HL) uses the latched HL snapshot for the high byte: the L written in LO must not corrupt the operand.
- Latency: start at edge k → write-back at k+1 (8-bit) or k+2 (16-bit); done high in the cycle after write-back.
- busy timing: high from edge k until the write-back edge.
- start while busy is ignored, not queued. ld_en while busy is ignored.
- Back-to-back: start may be asserted in the done cycle and is accepted, since state is IDLE then.
- Reset mid-command: abort immediately, restore reset values, no done pulse.

Test Plan:
- Reset release → reg_a=0x01, reg_f=0xB0, hl=0x014D, busy=0, done=0.
- Load A=0x3A, B=0xC6; start op=ADD, src=B, mask=1111 → 1 cycle later A=0x00, F=0xB0; done pulses once in the next cycle.
- Load A=0x3C; start op=CP, src=imm, imm8=0x40, mask=1111 → A stays 0x3C, F=0x50.
- Load A=0xFF, F=0x00; op=ADD, imm8=0x01, mask=1110 → A=0x00, F=0xA0 (C preserved at 0).
- Load H=0x8A, L=0x23, B=0x06, C=0x05, F=0x80; start is16=1, rr_sel=0 → after 2 busy cycles HL=0x9028, F=0xA0 (Z kept, H=1, C=0).
- During ADD16_HI, pulse start=1 → ignored and done occurs exactly once.
- Repeat the 16-bit command and assert rst during ADD16_HI → HL=0x014D, F=0xB0, state IDLE, no done.
